// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the BBTron Enhanced CPU: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath strobes per state.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       in_confirm,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dest,
  output logic       memto_reg,
  output logic       alu_src,
  output logic [3:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic       jump,
  output logic       in_signal,
  output logic       halted,
  output logic       mem_error,
  output logic [2:0] state
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000101;
  localparam logic [5:0] OP_IN   = 6'b000110;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_IN_WAIT = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q;
  logic          err_q, err_set;

  // The wait counter only runs inside MEM, so it is naturally zero on every MEM entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != S_MEM)
        wait_q <= '0;
      else if (!mem_ready && wait_q != LAST_WAIT)
        wait_q <= wait_q + CW'(1);
      if (err_set)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_set   = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dest  = 1'b0;
    memto_reg = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 4'b0000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    in_signal = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_J: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          OP_HLT:                              state_d = S_HALT;
          OP_IN:                               state_d = S_IN_WAIT;
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          default:                             state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op  = 4'b1111;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            alu_op   = 4'b0001;
            branch   = 1'b1;
            pc_write = zero;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode == OP_SW);
        if (mem_ready) begin
          state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
        end else if (wait_q == LAST_WAIT) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
      end
      S_WB: begin
        case (opcode)
          OP_R: begin
            reg_write = 1'b1;
            reg_dest  = 1'b1;
          end
          OP_ADDI: reg_write = 1'b1;
          OP_LW: begin
            reg_write = 1'b1;
            memto_reg = 1'b1;
          end
          default: ;
        endcase
        state_d = S_FETCH;
      end
      S_IN_WAIT: begin
        in_signal = 1'b1;
        alu_src   = 1'b1;
        reg_write = in_confirm;
        if (in_confirm)
          state_d = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Everything visible is held quiet while reset is asserted.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      reg_dest  = 1'b0;
      memto_reg = 1'b0;
      alu_src   = 1'b0;
      alu_op    = 4'b0000;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      in_signal = 1'b0;
      halted    = 1'b0;
    end
  end

  assign state     = reset ? 3'd0 : state_q;
  assign mem_error = err_q & ~reset;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: builds an expected per-cycle trace for each instruction from
// its CPI/strobe rules, then drives the recorded inputs and compares every cycle.
module tb_multicycle_control_unit;

  localparam int MEM_TIMEOUT = 8;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000101;
  localparam logic [5:0] OP_IN   = 6'b000110;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  // Packed strobe bits: {pc_write, ir_write, reg_write, reg_dest, memto_reg, alu_src,
  // alu_op[3:0], mem_read, mem_write, branch, jump, in_signal, halted}
  localparam logic [15:0] PCW = 16'h8000;
  localparam logic [15:0] IRW = 16'h4000;
  localparam logic [15:0] RW  = 16'h2000;
  localparam logic [15:0] RD  = 16'h1000;
  localparam logic [15:0] MTR = 16'h0800;
  localparam logic [15:0] AS  = 16'h0400;
  localparam logic [15:0] MR  = 16'h0020;
  localparam logic [15:0] MW  = 16'h0010;
  localparam logic [15:0] BR  = 16'h0008;
  localparam logic [15:0] JP  = 16'h0004;
  localparam logic [15:0] INS = 16'h0002;
  localparam logic [15:0] HL  = 16'h0001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0, in_confirm = 1'b0;
  logic       pc_write, ir_write, reg_write, reg_dest, memto_reg, alu_src;
  logic [3:0] alu_op;
  logic       mem_read, mem_write, branch, jump, in_signal, halted, mem_error;
  logic [2:0] state;

  multicycle_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .in_confirm(in_confirm),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dest(reg_dest), .memto_reg(memto_reg), .alu_src(alu_src),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .in_signal(in_signal), .halted(halted),
    .mem_error(mem_error), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [2:0]  st;
    logic [15:0] sb;
    logic        me;
    logic        mr;
    logic        ic;
    logic        z;
  } row_t;

  row_t       exp_q[$];
  logic [5:0] cur_op = 6'd0;
  int         errors = 0;
  int         checks = 0;
  int         row_id = 0;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] aop(input logic [3:0] v);
    return {6'b0, v, 6'b0};
  endfunction

  task automatic addRow(input logic [2:0] st, input logic [15:0] sb, input logic me,
                        input logic mr, input logic ic, input logic z);
    row_t r;
    r.rst = 1'b0; r.op = cur_op; r.st = st; r.sb = sb; r.me = me;
    r.mr = mr; r.ic = ic; r.z = z;
    exp_q.push_back(r);
  endtask

  task automatic addReset(input int n);
    row_t r;
    for (int i = 0; i < n; i++) begin
      r.rst = 1'b1; r.op = cur_op; r.st = 3'd0; r.sb = 16'h0; r.me = 1'b0;
      r.mr = rnd(); r.ic = rnd(); r.z = rnd();
      exp_q.push_back(r);
    end
  endtask

  task automatic addHalt(input int n, input logic me);
    for (int i = 0; i < n; i++) addRow(3'd6, HL, me, rnd(), rnd(), rnd());
  endtask

  // One instruction: FETCH row, then the rows its class needs. waits >= MEM_TIMEOUT
  // on LW/SW emits only the not-ready MEM cycles; the caller appends the halt.
  task automatic addInstr(input logic [5:0] op, input int waits, input logic z);
    cur_op = op;
    addRow(3'd0, PCW | IRW, 1'b0, rnd(), rnd(), rnd());
    if (op == OP_J) begin
      addRow(3'd1, PCW | JP, 1'b0, rnd(), rnd(), rnd());
      return;
    end
    addRow(3'd1, 16'h0, 1'b0, rnd(), rnd(), rnd());
    case (op)
      OP_IN: begin
        for (int i = 0; i < waits; i++) addRow(3'd5, INS | AS, 1'b0, rnd(), 1'b0, rnd());
        addRow(3'd5, INS | AS | RW, 1'b0, rnd(), 1'b1, rnd());
      end
      OP_R: begin
        addRow(3'd2, aop(4'hF), 1'b0, rnd(), rnd(), rnd());
        addRow(3'd4, RW | RD, 1'b0, rnd(), rnd(), rnd());
      end
      OP_ADDI: begin
        addRow(3'd2, AS, 1'b0, rnd(), rnd(), rnd());
        addRow(3'd4, RW, 1'b0, rnd(), rnd(), rnd());
      end
      OP_LW, OP_SW: begin
        addRow(3'd2, AS, 1'b0, rnd(), rnd(), rnd());
        if (waits >= MEM_TIMEOUT) begin
          for (int i = 0; i < MEM_TIMEOUT; i++)
            addRow(3'd3, (op == OP_LW) ? MR : MW, 1'b0, 1'b0, rnd(), rnd());
        end else begin
          for (int i = 0; i < waits; i++)
            addRow(3'd3, (op == OP_LW) ? MR : MW, 1'b0, 1'b0, rnd(), rnd());
          addRow(3'd3, (op == OP_LW) ? MR : MW, 1'b0, 1'b1, rnd(), rnd());
          if (op == OP_LW) addRow(3'd4, RW | MTR, 1'b0, rnd(), rnd(), rnd());
        end
      end
      OP_BEQ: addRow(3'd2, aop(4'h1) | BR | (z ? PCW : 16'h0), 1'b0, rnd(), rnd(), z);
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input row_t r);
    @(posedge clock);
    #1;
    reset      = r.rst;
    opcode     = r.op;
    mem_ready  = r.mr;
    in_confirm = r.ic;
    zero       = r.z;
    #1;
  endtask

  task automatic checkOutput(input row_t r);
    logic [15:0] obs;
    obs = {pc_write, ir_write, reg_write, reg_dest, memto_reg, alu_src, alu_op,
           mem_read, mem_write, branch, jump, in_signal, halted};
    checks++;
    assert (state === r.st && obs === r.sb && mem_error === r.me)
    else begin
      errors++;
      $error("[TB] FAIL row%0d op=%b rst=%b: got state=%0d strobes=%h mem_error=%b, want state=%0d strobes=%h mem_error=%b",
             row_id, r.op, r.rst, state, obs, mem_error, r.st, r.sb, r.me);
    end
    row_id++;
  endtask

  task automatic runQueue();
    row_t r;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      applyStimulus(r);
      checkOutput(r);
    end
  endtask

  initial begin
    logic [5:0] kinds [8];
    int         k;
    logic [5:0] op;
    kinds = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_IN, 6'd0};

    addReset(3);
    runQueue();

    addInstr(OP_R, 0, 1'b0);
    addInstr(OP_LW, 2, 1'b0);
    addInstr(OP_BEQ, 0, 1'b1);
    addInstr(OP_BEQ, 0, 1'b0);
    addInstr(OP_IN, 5, 1'b0);
    addInstr(OP_ADDI, 0, 1'b0);
    addInstr(OP_SW, 0, 1'b0);
    addInstr(OP_J, 0, 1'b0);
    addInstr(6'b100000, 0, 1'b0);
    addInstr(OP_LW, MEM_TIMEOUT - 1, 1'b0);
    addInstr(OP_SW, MEM_TIMEOUT - 1, 1'b0);
    addInstr(OP_IN, 0, 1'b0);
    runQueue();

    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 7);
      op = kinds[k];
      if (k == 7) op = 6'($urandom_range(7, 62));
      if (op == OP_LW || op == OP_SW)
        addInstr(op, $urandom_range(0, MEM_TIMEOUT - 2), 1'b0);
      else if (op == OP_IN)
        addInstr(op, $urandom_range(0, 4), 1'b0);
      else
        addInstr(op, 0, rnd());
      runQueue();
    end

    // Reset while an LW is stalled in MEM.
    cur_op = OP_LW;
    addRow(3'd0, PCW | IRW, 1'b0, rnd(), rnd(), rnd());
    addRow(3'd1, 16'h0, 1'b0, rnd(), rnd(), rnd());
    addRow(3'd2, AS, 1'b0, rnd(), rnd(), rnd());
    addRow(3'd3, MR, 1'b0, 1'b0, rnd(), rnd());
    addRow(3'd3, MR, 1'b0, 1'b0, rnd(), rnd());
    addReset(1);
    addInstr(OP_R, 0, 1'b0);
    runQueue();

    // SW with memory never ready: timeout halt with mem_error, then reset.
    addInstr(OP_SW, MEM_TIMEOUT, 1'b0);
    addHalt(5, 1'b1);
    addReset(2);
    addInstr(OP_LW, 1, 1'b0);
    runQueue();

    // HLT stays halted until reset.
    addInstr(OP_HLT, 0, 1'b0);
    addHalt(20, 1'b0);
    addReset(1);
    addInstr(OP_ADDI, 0, 1'b0);
    runQueue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
